romload_init: RTL and testbench

//  Bus initiator on the picorv32 native memory interface (mem_valid/mem_ready).

---
 rtl/romload_pkg.sv | 21 ++
 rtl/romload_mem_req.sv | 61 ++++++
 rtl/romload_init.sv | 213 +++++++++++++++++++++
 tb/tb_romload_init.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/romload_pkg.sv
// Shared types and constants for the boot-time ROM-to-RAM loader.
package romload_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CP_RD,
      CP_WR,
      VRD,
      CLR,
      FIN
   } state_t;

   localparam logic [31:0] WORD_BYTES = 32'd4;
   localparam logic [3:0]  WSTRB_RD   = 4'b0000;
   localparam logic [3:0]  WSTRB_WR   = 4'b1111;

   function automatic logic is_word_aligned(input logic [31:0] a);
      return (a[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/romload_mem_req.sv
// Single-outstanding request holder for the native memory port: registers one
// beat, keeps it stable until mem_ready, then pulses o_req_done with the read data.
module romload_mem_req
   import romload_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        i_issue,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   input  logic        i_mem_ready,
   input  logic [31:0] i_mem_rdata,
   output logic        o_mem_valid,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_wstrb,
   output logic        o_req_done,
   output logic [31:0] o_rdata
);

   logic        r_valid;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_done;
   logic [31:0] r_rdata;

   // Issue is only honoured while idle, which also enforces the idle cycle
   // between beats: completion and a new issue never share an edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= WSTRB_RD;
         r_done  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_done <= 1'b0;
         if (r_valid && i_mem_ready) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_rdata <= i_mem_rdata;
         end else if (i_issue && !r_valid) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_wstrb <= i_wstrb;
         end
      end
   end

   assign o_mem_valid = r_valid;
   assign o_mem_addr  = r_addr;
   assign o_mem_wdata = r_wdata;
   assign o_mem_wstrb = r_wstrb;
   assign o_req_done  = r_done;
   assign o_rdata     = r_rdata;

endmodule

// File: rtl/romload_init.sv
// Boot loader: copies .data from ROM to RAM, zero-fills .bss, then releases the core.
// Optional read-back verify of .data is enabled with `define ROMLOAD_VERIFY_EN.
module romload_init
   import romload_pkg::*;
#(
   parameter logic [31:0] DATA_LMA   = 32'h0001_0100,
   parameter logic [31:0] DATA_START = 32'h0001_0100,
   parameter logic [31:0] DATA_END   = 32'h0001_0100,
   parameter logic [31:0] BSS_END    = 32'h0001_0100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic        mem_valid,
   output logic        mem_instr,
   input  logic        mem_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic        cpu_resetn,
   output logic        error
);

   if (!is_word_aligned(DATA_LMA) || !is_word_aligned(DATA_START) ||
       !is_word_aligned(DATA_END) || !is_word_aligned(BSS_END) ||
       (DATA_END < DATA_START) || (BSS_END < DATA_END)) begin : g_param_err
      $error("romload_init: section parameters misaligned or out of order");
   end

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_off;
   logic [31:0] w_off_nxt;
   logic [31:0] r_ptr;
   logic [31:0] w_ptr_nxt;
   logic        r_done;
   logic        r_resetn;
   logic        w_issue;
   logic [31:0] w_addr;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic        w_leave;
   logic        w_req_done;
   logic [31:0] w_rdata;

`ifdef ROMLOAD_VERIFY_EN
   logic        r_vph;
   logic [31:0] r_vword;
   logic        r_error;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= IDLE;
         r_off    <= '0;
         r_ptr    <= '0;
         r_done   <= 1'b0;
         r_resetn <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_off    <= w_off_nxt;
         r_ptr    <= w_ptr_nxt;
         r_done   <= r_done | (r_state == FIN);
         r_resetn <= r_done;
      end
   end

   // The next beat is issued in the same cycle the previous one reports done,
   // so each beat costs exactly one valid cycle plus one idle cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_off_nxt   = r_off;
      w_ptr_nxt   = r_ptr;
      w_issue     = 1'b0;
      w_addr      = '0;
      w_wdata     = '0;
      w_wstrb     = WSTRB_RD;
      w_leave     = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               if (DATA_END != DATA_START) begin
                  w_state_nxt = CP_RD;
                  w_off_nxt   = '0;
                  w_issue     = 1'b1;
                  w_addr      = DATA_LMA;
               end else begin
                  w_leave = 1'b1;
               end
            end
         end
         CP_RD: begin
            if (w_req_done) begin
               w_state_nxt = CP_WR;
               w_issue     = 1'b1;
               w_addr      = DATA_START + r_off;
               w_wdata     = w_rdata;
               w_wstrb     = WSTRB_WR;
            end
         end
         CP_WR: begin
            if (w_req_done) begin
               w_off_nxt = r_off + WORD_BYTES;
               if (DATA_START + w_off_nxt == DATA_END) begin
`ifdef ROMLOAD_VERIFY_EN
                  w_state_nxt = VRD;
                  w_off_nxt   = '0;
                  w_issue     = 1'b1;
                  w_addr      = DATA_LMA;
`else
                  w_leave = 1'b1;
`endif
               end else begin
                  w_state_nxt = CP_RD;
                  w_issue     = 1'b1;
                  w_addr      = DATA_LMA + w_off_nxt;
               end
            end
         end
`ifdef ROMLOAD_VERIFY_EN
         VRD: begin
            // r_vph=0: ROM reference read done; r_vph=1: RAM read-back done.
            if (w_req_done) begin
               if (!r_vph) begin
                  w_issue = 1'b1;
                  w_addr  = DATA_START + r_off;
               end else begin
                  w_off_nxt = r_off + WORD_BYTES;
                  if (DATA_START + w_off_nxt == DATA_END) begin
                     w_leave = 1'b1;
                  end else begin
                     w_issue = 1'b1;
                     w_addr  = DATA_LMA + w_off_nxt;
                  end
               end
            end
         end
`endif
         CLR: begin
            if (w_req_done) begin
               w_ptr_nxt = r_ptr + WORD_BYTES;
               if (w_ptr_nxt == BSS_END) begin
                  w_state_nxt = FIN;
               end else begin
                  w_issue = 1'b1;
                  w_addr  = w_ptr_nxt;
                  w_wstrb = WSTRB_WR;
               end
            end
         end
         default: ;
      endcase
      if (w_leave) begin
         if (BSS_END != DATA_END) begin
            w_state_nxt = CLR;
            w_ptr_nxt   = DATA_END;
            w_issue     = 1'b1;
            w_addr      = DATA_END;
            w_wdata     = '0;
            w_wstrb     = WSTRB_WR;
         end else begin
            w_state_nxt = FIN;
         end
      end
   end

`ifdef ROMLOAD_VERIFY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_vph   <= 1'b0;
         r_vword <= '0;
         r_error <= 1'b0;
      end else if (r_state == VRD && w_req_done) begin
         if (!r_vph) begin
            r_vph   <= 1'b1;
            r_vword <= w_rdata;
         end else begin
            r_vph <= 1'b0;
            if (w_rdata != r_vword) r_error <= 1'b1;
         end
      end
   end
   assign error = r_error;
`else
   assign error = 1'b0;
`endif

   romload_mem_req u_req (
      .clk         (clk),
      .reset       (reset),
      .i_issue     (w_issue),
      .i_addr      (w_addr),
      .i_wdata     (w_wdata),
      .i_wstrb     (w_wstrb),
      .i_mem_ready (mem_ready),
      .i_mem_rdata (mem_rdata),
      .o_mem_valid (mem_valid),
      .o_mem_addr  (mem_addr),
      .o_mem_wdata (mem_wdata),
      .o_mem_wstrb (mem_wstrb),
      .o_req_done  (w_req_done),
      .o_rdata     (w_rdata)
   );

   assign mem_instr  = 1'b0;
   assign busy       = (r_state != IDLE) && (r_state != FIN);
   assign done       = r_done;
   assign cpu_resetn = r_resetn;

endmodule

// File: tb/tb_romload_init.sv
// Directed bench for romload_init: copy, bss clear, slow responder, reset mid-copy,
// start while busy, empty sections and read-back verify.
module tb_romload_init;

`ifdef ROMLOAD_VERIFY_EN
   localparam int unsigned EXP_LAT = 34;
   localparam int unsigned EXP_RD  = 12;
   localparam logic        EXP_ERR = 1'b1;
`else
   localparam int unsigned EXP_LAT = 18;
   localparam int unsigned EXP_RD  = 4;
   localparam logic        EXP_ERR = 1'b0;
`endif
   localparam int unsigned BOUND = 1000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   // instance 0: 4-word copy, no bss
   logic        start0 = 1'b0, valid0, instr0, ready0, busy0, done0, resetn0, err0;
   logic [31:0] addr0, wdata0, rdata0;
   logic [3:0]  wstrb0;
   // instance 1: bss only
   logic        start1 = 1'b0, valid1, instr1, ready1, busy1, done1, resetn1, err1;
   logic [31:0] addr1, wdata1, rdata1;
   logic [3:0]  wstrb1;
   // instance 2: everything empty
   logic        start2 = 1'b0, valid2, instr2, ready2, busy2, done2, resetn2, err2;
   logic [31:0] addr2, wdata2, rdata2;
   logic [3:0]  wstrb2;

   romload_init #(.DATA_LMA(32'h100), .DATA_START(32'h1000), .DATA_END(32'h1010), .BSS_END(32'h1010)) u_copy (
      .clk(clk), .reset(rst), .start(start0), .mem_valid(valid0), .mem_instr(instr0),
      .mem_ready(ready0), .mem_addr(addr0), .mem_wdata(wdata0), .mem_wstrb(wstrb0),
      .mem_rdata(rdata0), .busy(busy0), .done(done0), .cpu_resetn(resetn0), .error(err0));

   romload_init #(.DATA_LMA(32'h2000), .DATA_START(32'h2000), .DATA_END(32'h2000), .BSS_END(32'h2008)) u_bss (
      .clk(clk), .reset(rst), .start(start1), .mem_valid(valid1), .mem_instr(instr1),
      .mem_ready(ready1), .mem_addr(addr1), .mem_wdata(wdata1), .mem_wstrb(wstrb1),
      .mem_rdata(rdata1), .busy(busy1), .done(done1), .cpu_resetn(resetn1), .error(err1));

   romload_init u_empty (
      .clk(clk), .reset(rst), .start(start2), .mem_valid(valid2), .mem_instr(instr2),
      .mem_ready(ready2), .mem_addr(addr2), .mem_wdata(wdata2), .mem_wstrb(wstrb2),
      .mem_rdata(rdata2), .busy(busy2), .done(done2), .cpu_resetn(resetn2), .error(err2));

   // ---------------- responders / monitors ----------------
   logic [31:0] exp_data [4] = '{32'hCAFE_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0BAD_F00D};
   logic [31:0] rom0 [4];
   logic [31:0] ram0 [4];
   logic [31:0] ram1 [2];
   logic        ram_fill = 1'b0;
   logic        corrupt0 = 1'b0;
   int          dly0 = 0;
   int          wcnt0 = 0;
   int          wr0 = 0, rd0 = 0, stab0 = 0, beats1 = 0, wrf1 = 0, beats2 = 0;
   logic [31:0] wr_log0[$];
   logic        pv0 = 1'b0;
   logic [31:0] pa0 = '0, pd0 = '0;
   logic [3:0]  ps0 = '0;

   initial for (int i = 0; i < 4; i++) rom0[i] = exp_data[i];

   assign ready0 = valid0 && (wcnt0 >= dly0);
   assign rdata0 = addr0[12] ? ram0[addr0[3:2]] : rom0[addr0[3:2]];
   assign ready1 = valid1;
   assign rdata1 = 32'h0;
   assign ready2 = valid2;
   assign rdata2 = 32'h0;

   always @(posedge clk) begin
      if (rst || !valid0 || ready0) wcnt0 <= 0;
      else wcnt0 <= wcnt0 + 1;
      if (ram_fill) begin
         for (int i = 0; i < 4; i++) ram0[i] <= 32'hFFFF_FFFF;
      end else if (valid0 && ready0) begin
         if (wstrb0 == 4'hF) begin
            ram0[addr0[3:2]] <= (corrupt0 && addr0 == 32'h1004) ? ~wdata0 : wdata0;
            wr0 <= wr0 + 1;
            wr_log0.push_back(addr0);
         end else begin
            rd0 <= rd0 + 1;
         end
      end
   end

   always @(posedge clk) begin
      if (ram_fill) begin
         ram1[0] <= 32'hFFFF_FFFF;
         ram1[1] <= 32'hFFFF_FFFF;
      end else if (valid1 && ready1) begin
         beats1 <= beats1 + 1;
         if (wstrb1 == 4'hF) begin
            wrf1 <= wrf1 + 1;
            ram1[addr1[2]] <= wdata1;
         end
      end
      if (valid2 && ready2) beats2 <= beats2 + 1;
   end

   // request fields must not move while a beat is outstanding
   always @(negedge clk) begin
      if (pv0 && valid0 && (addr0 != pa0 || wdata0 != pd0 || wstrb0 != ps0)) stab0 <= stab0 + 1;
      pv0 <= valid0;
      pa0 <= addr0;
      pd0 <= wdata0;
      ps0 <= wstrb0;
   end

   // ---------------- driver tasks (entered and left at a negedge) ----------------
   task automatic do_reset();
      rst = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic fill_ram();
      ram_fill = 1'b1;
      @(negedge clk);
      ram_fill = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_start(input int which, output int unsigned t0);
      t0 = cyc;
      if (which == 0) start0 = 1'b1;
      else if (which == 1) start1 = 1'b1;
      else start2 = 1'b1;
      @(negedge clk);
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
   endtask

   task automatic wait_done(input int which, input int unsigned t0, output int unsigned lat);
      int unsigned i = 0;
      logic d;
      d = (which == 0) ? done0 : (which == 1) ? done1 : done2;
      while (!d && i < BOUND) begin
         @(negedge clk);
         i++;
         d = (which == 0) ? done0 : (which == 1) ? done1 : done2;
      end
      lat = d ? (cyc - t0) : 32'hFFFF_FFFF;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({valid0, instr0, busy0, done0, resetn0, err0} !== 6'b0) begin
         n_err++; $display("FAIL reset_ctrl0: got %b expected 000000", {valid0, instr0, busy0, done0, resetn0, err0});
      end
      n_cmp++;
      if ({addr0, wdata0, wstrb0} !== 68'h0) begin
         n_err++; $display("FAIL reset_bus0: addr %h wdata %h wstrb %b expected zeros", addr0, wdata0, wstrb0);
      end
      n_cmp++;
      if ({valid1, instr1, busy1, done1, resetn1, err1, valid2, instr2, busy2, done2, resetn2, err2} !== 12'b0) begin
         n_err++; $display("FAIL reset_ctrl12: got %b expected all 0",
                           {valid1, instr1, busy1, done1, resetn1, err1, valid2, instr2, busy2, done2, resetn2, err2});
      end
      n_cmp++;
      if ({addr1, wdata1, wstrb1, addr2, wdata2, wstrb2} !== 136'h0) begin
         n_err++; $display("FAIL reset_bus12: addr1 %h addr2 %h expected zeros", addr1, addr2);
      end
   endtask

   task automatic test_copy();
      int unsigned t0, lat;
      int wr_b, rd_b, lg_b;
      do_reset();
      fill_ram();
      wr_b = wr0; rd_b = rd0; lg_b = wr_log0.size();
      pulse_start(0, t0);
      n_cmp++;
      if ({busy0, valid0, wstrb0} !== 6'b110000) begin
         n_err++; $display("FAIL copy_first_beat: busy/valid/wstrb %b expected 110000", {busy0, valid0, wstrb0});
      end
      wait_done(0, t0, lat);
      n_cmp++;
      if (lat !== EXP_LAT) begin n_err++; $display("FAIL copy_latency: got %0d expected %0d", lat, EXP_LAT); end
      n_cmp++;
      if ({busy0, resetn0} !== 2'b00) begin n_err++; $display("FAIL copy_at_done: busy/resetn %b expected 00", {busy0, resetn0}); end
      @(negedge clk);
      n_cmp++;
      if ({done0, resetn0, err0} !== 3'b110) begin
         n_err++; $display("FAIL copy_release: done/resetn/error %b expected 110", {done0, resetn0, err0});
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (ram0[i] !== exp_data[i]) begin n_err++; $display("FAIL copy_ram[%0d]: got %h expected %h", i, ram0[i], exp_data[i]); end
      end
      n_cmp++;
      if ((wr0 - wr_b) != 4 || (rd0 - rd_b) != int'(EXP_RD)) begin
         n_err++; $display("FAIL copy_beats: wr %0d rd %0d expected 4 %0d", wr0 - wr_b, rd0 - rd_b, EXP_RD);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (wr_log0[lg_b + i] !== 32'h1000 + 32'(4 * i)) begin
            n_err++; $display("FAIL copy_wr_order[%0d]: got %h expected %h", i, wr_log0[lg_b + i], 32'h1000 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_bss();
      int unsigned t0, lat;
      int b_b, w_b;
      do_reset();
      fill_ram();
      b_b = beats1; w_b = wrf1;
      pulse_start(1, t0);
      wait_done(1, t0, lat);
      n_cmp++;
      if (lat !== 6) begin n_err++; $display("FAIL bss_latency: got %0d expected 6", lat); end
      @(negedge clk);
      n_cmp++;
      if ({ram1[0], ram1[1]} !== 64'h0) begin n_err++; $display("FAIL bss_clear: got %h %h expected 0 0", ram1[0], ram1[1]); end
      n_cmp++;
      if ((beats1 - b_b) != 2 || (wrf1 - w_b) != 2) begin
         n_err++; $display("FAIL bss_beats: total %0d full-strobe writes %0d expected 2 2", beats1 - b_b, wrf1 - w_b);
      end
      n_cmp++;
      if ({busy1, resetn1, err1} !== 3'b010) begin n_err++; $display("FAIL bss_status: busy/resetn/error %b expected 010", {busy1, resetn1, err1}); end
   endtask

   task automatic test_slow_responder();
      int unsigned t0, lat;
      int wr_b, rd_b, st_b, lg_b;
      do_reset();
      fill_ram();
      dly0 = 5;
      wr_b = wr0; rd_b = rd0; st_b = stab0; lg_b = wr_log0.size();
      pulse_start(0, t0);
      wait_done(0, t0, lat);
      dly0 = 0;
      n_cmp++;
      if (lat == 32'hFFFF_FFFF) begin n_err++; $display("FAIL slow_timeout: done not seen within %0d cycles", BOUND); end
      n_cmp++;
      if (stab0 != st_b) begin n_err++; $display("FAIL slow_stability: %0d changes while valid expected 0", stab0 - st_b); end
      n_cmp++;
      if ((wr0 - wr_b) != 4 || (rd0 - rd_b) != int'(EXP_RD)) begin
         n_err++; $display("FAIL slow_beats: wr %0d rd %0d expected 4 %0d", wr0 - wr_b, rd0 - rd_b, EXP_RD);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (ram0[i] !== exp_data[i] || wr_log0[lg_b + i] !== 32'h1000 + 32'(4 * i)) begin
            n_err++; $display("FAIL slow_ram[%0d]: got %h at %h expected %h at %h", i, ram0[i], wr_log0[lg_b + i],
                              exp_data[i], 32'h1000 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_reset_mid_copy();
      int unsigned t0, lat, i;
      int wr_b;
      do_reset();
      fill_ram();
      wr_b = wr0;
      pulse_start(0, t0);
      i = 0;
      while (!((wr0 - wr_b) == 1 && valid0 && wstrb0 == 4'hF) && i < BOUND) begin
         @(negedge clk);
         i++;
      end
      n_cmp++;
      if (i >= BOUND) begin n_err++; $display("FAIL midrst_find_beat: 2nd write beat not seen within %0d cycles", BOUND); end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({valid0, done0, resetn0, busy0} !== 4'b0000) begin
         n_err++; $display("FAIL midrst_immediate: valid/done/resetn/busy %b expected 0000", {valid0, done0, resetn0, busy0});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({valid0, busy0, done0} !== 3'b000) begin
         n_err++; $display("FAIL midrst_stays_idle: valid/busy/done %b expected 000", {valid0, busy0, done0});
      end
      fill_ram();
      pulse_start(0, t0);
      wait_done(0, t0, lat);
      n_cmp++;
      if (lat !== EXP_LAT) begin n_err++; $display("FAIL midrst_rerun_latency: got %0d expected %0d", lat, EXP_LAT); end
      for (int k = 0; k < 4; k++) begin
         n_cmp++;
         if (ram0[k] !== exp_data[k]) begin n_err++; $display("FAIL midrst_ram[%0d]: got %h expected %h", k, ram0[k], exp_data[k]); end
      end
   endtask

   task automatic test_back_to_back();
      int unsigned t0, t1, lat;
      int wr_b, rd_b, b2_b;
      do_reset();
      fill_ram();
      wr_b = wr0; rd_b = rd0;
      pulse_start(0, t0);
      repeat (4) @(negedge clk);
      pulse_start(0, t1);
      wait_done(0, t0, lat);
      n_cmp++;
      if (lat !== EXP_LAT) begin n_err++; $display("FAIL busy_start_latency: got %0d expected %0d", lat, EXP_LAT); end
      @(negedge clk);
      n_cmp++;
      if ((wr0 - wr_b) != 4 || (rd0 - rd_b) != int'(EXP_RD)) begin
         n_err++; $display("FAIL busy_start_beats: wr %0d rd %0d expected 4 %0d", wr0 - wr_b, rd0 - rd_b, EXP_RD);
      end
      b2_b = beats2;
      pulse_start(2, t0);
      wait_done(2, t0, lat);
      n_cmp++;
      if (lat !== 2) begin n_err++; $display("FAIL empty_latency: got %0d expected 2", lat); end
      n_cmp++;
      if (resetn2 !== 1'b0) begin n_err++; $display("FAIL empty_resetn_at_done: got %b expected 0", resetn2); end
      @(negedge clk);
      n_cmp++;
      if ({resetn2, busy2, beats2 - b2_b} !== {2'b10, 32'd0}) begin
         n_err++; $display("FAIL empty_after: resetn %b busy %b beats %0d expected 1 0 0", resetn2, busy2, beats2 - b2_b);
      end
   endtask

   task automatic test_verify();
      int unsigned t0, lat;
      do_reset();
      fill_ram();
      corrupt0 = 1'b1;
      pulse_start(0, t0);
      wait_done(0, t0, lat);
      corrupt0 = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({done0, err0} !== {1'b1, EXP_ERR}) begin
         n_err++; $display("FAIL verify_error: done/error %b expected %b", {done0, err0}, {1'b1, EXP_ERR});
      end
   endtask

   initial begin
      test_reset();
      test_copy();
      test_bss();
      test_slow_responder();
      test_reset_mid_copy();
      test_back_to_back();
      test_verify();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
